// File: rtl/wb_stream_bridge.sv
// wb_stream_bridge: Wishbone register slave feeding a TX FIFO to AXI-Stream and draining an RX FIFO from AXI-Stream.
// Define WB_STREAM_IRQ_EN to drive irq from a registered copy of DONE; otherwise irq is tied low.
module wb_stream_bridge #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wb_valid,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [DW-1:0] wbs_dat_i,
    input  logic [31:0]   wbs_adr_i,
    output logic          wbs_ack_o,
    output logic [DW-1:0] wbs_dat_o,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tlast,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tlast,
    output logic          irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DW-1:0] tx_mem_q [DEPTH];
    logic [DW-1:0] rx_mem_q [DEPTH];
    logic [AW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic          start_q, start_d, done_q, done_d, under_q, under_d, ack_q, ack_d;
    logic [15:0]   len_q, len_d, cnt_q, cnt_d, len_eff;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          sel_ctrl, sel_len, sel_tx, sel_rx;
    logic          wr_cyc, rd_cyc, ctrl_wr, clr;
    logic          tx_push, tx_pop, rx_push, rx_pop, last_beat;
    logic [DW-1:0] rdata;
    logic          unused_bits;

    assign unused_bits = ^{wbs_adr_i[31:8], wbs_sel_i[3:2]};

    assign tx_full  = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
    assign tx_empty = tx_wr_q == tx_rd_q;
    assign rx_full  = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);
    assign rx_empty = rx_wr_q == rx_rd_q;

    assign sel_ctrl = wbs_adr_i[7:0] == 8'h00;
    assign sel_len  = wbs_adr_i[7:0] == 8'h04;
    assign sel_tx   = wbs_adr_i[7:0] == 8'h10;
    assign sel_rx   = wbs_adr_i[7:0] == 8'h14;

    // Register side effects all happen in the ack cycle, while the master still holds the request.
    assign wr_cyc  = ack_q & wbs_we_i;
    assign rd_cyc  = ack_q & ~wbs_we_i;
    assign ctrl_wr = wr_cyc & sel_ctrl;
    assign clr     = ctrl_wr & wbs_dat_i[1];

    assign m_axis_tvalid = start_q & ~tx_empty;
    assign m_axis_tdata  = tx_mem_q[tx_rd_q[AW-1:0]];
    assign len_eff       = (len_q == 16'd0) ? 16'd1 : len_q;
    assign last_beat     = cnt_q == len_eff - 16'd1;
    assign m_axis_tlast  = m_axis_tvalid & last_beat;
    assign s_axis_tready = wb_rst_i & ~rx_full;

    assign tx_pop  = m_axis_tvalid & m_axis_tready;
    assign tx_push = wr_cyc & sel_tx & (~tx_full | tx_pop);
    assign rx_push = s_axis_tvalid & s_axis_tready;
    assign rx_pop  = rd_cyc & sel_rx & ~rx_empty;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rd_cyc ? rdata : '0;

    always_comb begin
        rdata = '0;
        if (sel_ctrl)
            rdata[6:0] = {under_q, done_q, rx_empty, rx_full, tx_empty, tx_full, start_q};
        else if (sel_len)
            rdata[15:0] = len_q;
        else if (sel_rx && !rx_empty)
            rdata = rx_mem_q[rx_rd_q[AW-1:0]];
    end

    always_comb begin
        // A TX write into a full FIFO waits for a stream beat that frees a slot.
        ack_d   = wb_valid & ~ack_q & ~(wbs_we_i & sel_tx & tx_full & ~tx_pop);
        start_d = ctrl_wr ? wbs_dat_i[0] : start_q;
        len_d   = len_q;
        if (wr_cyc && sel_len) begin
            if (wbs_sel_i[0]) len_d[7:0] = wbs_dat_i[7:0];
            if (wbs_sel_i[1]) len_d[15:8] = wbs_dat_i[15:8];
        end
        tx_wr_d = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
        tx_rd_d = tx_pop ? tx_rd_q + PTR_ONE : tx_rd_q;
        rx_wr_d = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
        rx_rd_d = rx_pop ? rx_rd_q + PTR_ONE : rx_rd_q;
        cnt_d   = tx_pop ? (last_beat ? 16'd0 : cnt_q + 16'd1) : cnt_q;
        done_d  = (rx_push & s_axis_tlast) | (done_q & ~(ctrl_wr & wbs_dat_i[5]));
        under_d = (rd_cyc & sel_rx & rx_empty) | (under_q & ~(ctrl_wr & wbs_dat_i[6]));
        if (clr) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
            rx_wr_d = '0;
            rx_rd_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            under_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q   <= 1'b0;
            start_q <= 1'b0;
            len_q   <= 16'd1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            ack_q   <= ack_d;
            start_q <= start_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            under_q <= under_d;
            tx_wr_q <= tx_wr_d;
            tx_rd_q <= tx_rd_d;
            rx_wr_q <= rx_wr_d;
            rx_rd_q <= rx_rd_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
        end else begin
            if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= wbs_dat_i;
            if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= s_axis_tdata;
        end
    end

`ifdef WB_STREAM_IRQ_EN
    logic irq_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) irq_q <= 1'b0;
        else irq_q <= done_q;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule
